// File: rtl/paula_audio_pkg.sv
// Shared constants and width helpers for the Paula PDM receive path.
// Accumulator width and PCM scaling both derive from CIC order and decimation ratio.
package paula_audio_pkg;

  localparam int PCM_W   = 15;
  localparam int PCM_MAX = 16383;
  localparam int PCM_MIN = -16384;

  typedef logic signed [PCM_W-1:0] pcm_t;

  // Bit growth of an ORDER-stage CIC at ratio 2^dec_log2, plus sign and the +full-scale code.
  function automatic int acc_w(input int order, input int dec_log2);
    return 2 + order * dec_log2;
  endfunction

  // Positive: left shift into PCM range; negative: arithmetic right shift.
  function automatic int scale_shift(input int order, input int dec_log2);
    return 14 - order * dec_log2;
  endfunction

endpackage

// File: rtl/paula_audio_cic_decim.sv
// One channel of the PDM decoder: CIC integrators, tick-rate comb, scale/saturate.
// Optional DC blocker after saturation when PAULA_AUDIO_PDM_DCBLOCK_EN is defined.
module paula_audio_cic_decim
  import paula_audio_pkg::*;
#(
  parameter int DEC_LOG2 = 4,
  parameter int ORDER    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       tick,
  input  logic       bit_in,
  output pcm_t       pcm
);

  localparam int ACC_W = acc_w(ORDER, DEC_LOG2);
  localparam int SHIFT = scale_shift(ORDER, DEC_LOG2);
  localparam int SHL   = (SHIFT > 0) ? SHIFT : 0;
  localparam int SHR   = (SHIFT < 0) ? -SHIFT : 0;

  typedef logic signed [ACC_W-1:0] acc_t;

  acc_t x_in;
  acc_t integ    [ORDER];
  acc_t comb_dly [ORDER];
  acc_t comb     [ORDER];
  pcm_t pcm_p1;

  function automatic pcm_t scale_sat(input acc_t v);
    logic signed [31:0] w;
    w = {{(32-ACC_W){v[ACC_W-1]}}, v};
    w = (w <<< SHL) >>> SHR;
    if (w > PCM_MAX) return PCM_W'(PCM_MAX);
    if (w < PCM_MIN) return PCM_W'(PCM_MIN);
    return w[PCM_W-1:0];
  endfunction

  assign x_in = bit_in ? acc_t'(1) : '1;

  // Integrator stages: modulo-2^ACC_W wrap is intentional; the comb undoes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (clk7_en) begin
      integ[0] <= integ[0] + x_in;
      for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_comb begin
    comb[0] = integ[ORDER-1] - comb_dly[0];
    for (int k = 1; k < ORDER; k++) comb[k] = comb[k-1] - comb_dly[k];
  end

  // Comb delay line and output register advance at the decimated tick only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) comb_dly[k] <= '0;
      pcm_p1 <= '0;
    end else if (tick) begin
      comb_dly[0] <= integ[ORDER-1];
      for (int k = 1; k < ORDER; k++) comb_dly[k] <= comb[k-1];
      pcm_p1 <= scale_sat(comb[ORDER-1]);
    end
  end

`ifdef PAULA_AUDIO_PDM_DCBLOCK_EN
  logic               vld_p1;
  pcm_t               dc_x_prev;
  pcm_t               dc_y_p2;
  logic signed [16:0] x17;
  logic signed [16:0] xp17;
  logic signed [16:0] yp17;
  logic signed [16:0] dc_sum;

  function automatic pcm_t dc_sat(input logic signed [16:0] v);
    if (v > 17'sd16383) return PCM_W'(PCM_MAX);
    if (v < -17'sd16384) return PCM_W'(PCM_MIN);
    return v[PCM_W-1:0];
  endfunction

  assign x17    = {{2{pcm_p1[PCM_W-1]}}, pcm_p1};
  assign xp17   = {{2{dc_x_prev[PCM_W-1]}}, dc_x_prev};
  assign yp17   = {{2{dc_y_p2[PCM_W-1]}}, dc_y_p2};
  assign dc_sum = x17 - xp17 + yp17 - (yp17 >>> 8);

  // DC blocker runs once per new CIC sample, one clk after the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      dc_x_prev <= '0;
      dc_y_p2   <= '0;
    end else begin
      vld_p1 <= tick;
      if (vld_p1) begin
        dc_x_prev <= pcm_p1;
        dc_y_p2   <= dc_sat(dc_sum);
      end
    end
  end

  assign pcm = dc_y_p2;
`else
  assign pcm = pcm_p1;
`endif

endmodule

// File: rtl/paula_audio_pdm_decoder.sv
// Stereo 1-bit PDM to 15-bit PCM decoder: shared decimation counter, two CIC channels.
// Define PAULA_AUDIO_PDM_DCBLOCK_EN to add a DC blocker (one extra clk of latency).
module paula_audio_pdm_decoder
  import paula_audio_pkg::*;
#(
  parameter int DEC_LOG2 = 4,
  parameter int ORDER    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk7_en,
  input  logic                    left_in,
  input  logic                    right_in,
  output logic signed [PCM_W-1:0] ldata,
  output logic signed [PCM_W-1:0] rdata,
  output logic                    sample_valid
);

  logic [DEC_LOG2-1:0] dec_cnt;
  logic                tick;
  logic                vld_p1;

  assign tick = clk7_en && (dec_cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= tick;
      if (clk7_en) dec_cnt <= dec_cnt + 1'b1;
    end
  end

`ifdef PAULA_AUDIO_PDM_DCBLOCK_EN
  logic vld_p2;

  always_ff @(posedge clk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  assign sample_valid = vld_p2;
`else
  assign sample_valid = vld_p1;
`endif

  paula_audio_cic_decim #(
    .DEC_LOG2 (DEC_LOG2),
    .ORDER    (ORDER)
  ) u_left (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .tick    (tick),
    .bit_in  (left_in),
    .pcm     (ldata)
  );

  paula_audio_cic_decim #(
    .DEC_LOG2 (DEC_LOG2),
    .ORDER    (ORDER)
  ) u_right (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .tick    (tick),
    .bit_in  (right_in),
    .pcm     (rdata)
  );

endmodule
